// File: rtl/core_pkg.sv
// Types and constants shared by the front-end pipeline stages (fetch_unit, instr_reg).
// Holds the canonical NOP encoding and the fetch FSM state type.
package core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding I-cache request, and buffers one
// returned instruction for IF/ID. Redirects flush the buffer and drop any in-flight response.
module fetch_unit
    import core_pkg::*;
#(
    parameter int            n        = 32,
    parameter logic [n-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          L1_busy,
    input  logic          redirect_valid,
    input  logic [n-1:0]  redirect_pc,
    output logic          imem_req,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [n-1:0]  imem_rdata,
    output logic [n-1:0]  instruction_next,
    output logic [n-1:0]  pc_next,
    output logic [n-1:0]  pc_plus_four_next,
    output logic          fetch_busy
);

    localparam logic [n-1:0] NOP  = n'(NOP_INSTR);
    localparam logic [n-1:0] FOUR = n'(4);

    fetch_state_t  state, state_nxt;
    logic [n-1:0]  pc, pc_nxt;
    logic [n-1:0]  buf_instr, buf_instr_nxt;
    logic [n-1:0]  buf_pc, buf_pc_nxt;
    logic          buf_valid, buf_valid_nxt;
    logic          consume;
    logic          fill;
    logic [n-1:0]  redirect_target;

    assign consume         = buf_valid & ~L1_busy;
    assign redirect_target = redirect_pc & ~n'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            buf_valid <= 1'b0;
            buf_instr <= NOP;
            buf_pc    <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_valid <= buf_valid_nxt;
            buf_instr <= buf_instr_nxt;
            buf_pc    <= buf_pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        buf_valid_nxt = buf_valid;
        buf_instr_nxt = buf_instr;
        buf_pc_nxt    = buf_pc;
        imem_req      = 1'b0;
        fill          = 1'b0;

        if (consume)
            buf_valid_nxt = 1'b0;

        case (state)
            S_REQ: begin
                // Only ask for a new word when the buffer will have room for it at the fill edge.
                imem_req = (~buf_valid | consume) & ~redirect_valid & ~reset;
                if (imem_req && imem_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    fill      = ~redirect_valid;
                end else if (redirect_valid) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase

        if (fill) begin
            buf_valid_nxt = 1'b1;
            buf_instr_nxt = imem_rdata;
            buf_pc_nxt    = pc;
            pc_nxt        = pc + FOUR;
        end

        if (redirect_valid) begin
            pc_nxt        = redirect_target;
            buf_valid_nxt = 1'b0;
        end
    end

    assign imem_addr         = pc;
    assign instruction_next  = buf_valid ? buf_instr : NOP;
    assign pc_next           = buf_pc;
    assign pc_plus_four_next = buf_pc + FOUR;
    assign fetch_busy        = ~buf_valid;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!imem_rvalid || state == S_WAIT || state == S_DRAIN)
                else $error("fetch_unit: imem_rvalid with no request outstanding");
            assert (imem_addr[1:0] == 2'b00)
                else $error("fetch_unit: misaligned imem_addr");
            assert (!(fill && buf_valid && !consume))
                else $error("fetch_unit: fill into an occupied buffer");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural I-cache with programmable latency, a scoreboard of
// expected IF/ID words, a cycle vector table and hand sequences for redirect/reset corners.
module tb_fetch_unit;
    import core_pkg::*;

    localparam logic [31:0] PC2 = 32'hFFFFFFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        L1_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instruction_next, instruction_next2;
    logic [31:0] pc_next, pc_next2;
    logic [31:0] pc_plus_four_next, pc_plus_four_next2;
    logic        fetch_busy, fetch_busy2;

    always #5 clk = ~clk;

    fetch_unit #(.n(32), .RESET_PC(32'h00000000)) dut (
        .clk(clk), .reset(reset), .L1_busy(L1_busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_next(instruction_next), .pc_next(pc_next),
        .pc_plus_four_next(pc_plus_four_next), .fetch_busy(fetch_busy)
    );

    // Same stimulus, PC starting just below the wrap point.
    fetch_unit #(.n(32), .RESET_PC(PC2)) dut_wrap (
        .clk(clk), .reset(reset), .L1_busy(L1_busy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_next(instruction_next2), .pc_next(pc_next2),
        .pc_plus_four_next(pc_plus_four_next2), .fetch_busy(fetch_busy2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        busy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fb;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[12];
    logic        pend;
    logic        stale;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          cnt;
    int          lat;
    logic        ready_cfg;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h00500093 ^ (a << 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        L1_busy        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        imem_ready     = 1'b1;
        ready_cfg      = 1'b1;
        lat            = 1;
        pend           = 1'b0;
        stale          = 1'b0;
        cnt            = 0;
        exp_pc         = 32'h0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs plus the cache response, then run the scoreboard.
    task automatic cyc(input logic busy, input logic redir, input logic [31:0] rpc);
        exp_t e;
        L1_busy        = busy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ready     = ready_cfg;
        if (pend && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        if (redirect_valid)
            chk("req_during_redirect", {31'b0, imem_req}, 32'h0);
        chk("fetch_busy_model", {31'b0, fetch_busy}, {31'b0, exp_q.size() == 0});
        if (!fetch_busy && !L1_busy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("consume_instr", instruction_next, e.instr);
            chk("consume_pc", pc_next, e.pc);
            chk("consume_pc4", pc_plus_four_next, e.pc + 32'd4);
        end else if (fetch_busy) begin
            chk("nop_when_empty", instruction_next, NOP_INSTR);
        end
        if (imem_rvalid) begin
            if (!stale && !redirect_valid) begin
                exp_q.push_back('{pc: pend_addr, instr: imem_rdata});
                exp_pc = pend_addr + 32'd4;
            end
            pend  = 1'b0;
            stale = 1'b0;
        end else if (pend) begin
            cnt--;
        end
        if (imem_req && imem_ready) begin
            chk("req_addr_model", imem_addr, exp_pc);
            chk("single_outstanding", {31'b0, pend}, 32'h0);
            pend      = 1'b1;
            pend_addr = imem_addr;
            cnt       = lat - 1;
        end
        if (redirect_valid) begin
            if (pend) stale = 1'b1;
            exp_pc = redirect_pc & ~32'd3;
            exp_q.delete();
        end
    endtask

    initial begin
        // Sequential fetch and a 5-cycle L1_busy hold, one row per cycle.
        vecs[0]  = '{busy: 1'b0, e_req: 1'b1, e_addr: 32'd0,  e_fb: 1'b1, e_instr: NOP_INSTR,       e_pc: 32'd0};
        vecs[1]  = '{busy: 1'b0, e_req: 1'b0, e_addr: 32'd0,  e_fb: 1'b1, e_instr: NOP_INSTR,       e_pc: 32'd0};
        vecs[2]  = '{busy: 1'b0, e_req: 1'b1, e_addr: 32'd4,  e_fb: 1'b0, e_instr: 32'h00500093,    e_pc: 32'd0};
        vecs[3]  = '{busy: 1'b0, e_req: 1'b0, e_addr: 32'd0,  e_fb: 1'b1, e_instr: NOP_INSTR,       e_pc: 32'd0};
        for (int i = 4; i < 9; i++)
            vecs[i] = '{busy: 1'b1, e_req: 1'b0, e_addr: 32'd0, e_fb: 1'b0, e_instr: 32'h00540093, e_pc: 32'd4};
        vecs[9]  = '{busy: 1'b0, e_req: 1'b1, e_addr: 32'd8,  e_fb: 1'b0, e_instr: 32'h00540093,    e_pc: 32'd4};
        vecs[10] = '{busy: 1'b0, e_req: 1'b0, e_addr: 32'd0,  e_fb: 1'b1, e_instr: NOP_INSTR,       e_pc: 32'd0};
        vecs[11] = '{busy: 1'b0, e_req: 1'b1, e_addr: 32'd12, e_fb: 1'b0, e_instr: 32'h00580093,    e_pc: 32'd8};

        // Reset values while reset is held.
        reset          = 1'b1;
        L1_busy        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr", instruction_next, NOP_INSTR);
        chk("rst_pc", pc_next, 32'h0);
        chk("rst_fetch_busy", {31'b0, fetch_busy}, 32'h1);
        chk("rst_wrap_pc", pc_next2, PC2);

        // Vector table: first fetch, throughput, stall hold and release.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].busy, 1'b0, 32'h0);
            chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_fetch_busy", i), {31'b0, fetch_busy}, {31'b0, vecs[i].e_fb});
            chk($sformatf("vec%0d_instr", i), instruction_next, vecs[i].e_instr);
            if (!vecs[i].e_fb)
                chk($sformatf("vec%0d_pc", i), pc_next, vecs[i].e_pc);
            adv();
        end

        // Redirect while waiting; stale response arrives two cycles later via S_DRAIN.
        do_reset();
        lat = 3;
        cyc(1'b0, 1'b0, 32'h0);   adv();
        cyc(1'b0, 1'b1, 32'h100); adv();
        lat = 1;
        cyc(1'b0, 1'b0, 32'h0);
        chk("drain_req", {31'b0, imem_req}, 32'h0);
        adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("drain_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
        chk("drain_stale_hidden", instruction_next, NOP_INSTR);
        adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("drain_next_req", {31'b0, imem_req}, 32'h1);
        chk("drain_next_addr", imem_addr, 32'h100);
        chk("drain_still_nop", instruction_next, NOP_INSTR);
        adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("drain_target_instr", instruction_next, instr_of(32'h100));
        adv();

        // Ready low holds the request; redirect coincident with rvalid skips S_DRAIN.
        do_reset();
        ready_cfg = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);
        chk("notready_req", {31'b0, imem_req}, 32'h1);
        adv();
        ready_cfg = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);
        chk("notready_held_addr", imem_addr, 32'h0);
        adv();
        cyc(1'b0, 1'b1, 32'h203); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("sameclk_req", {31'b0, imem_req}, 32'h1);
        chk("sameclk_addr", imem_addr, 32'h200);
        chk("sameclk_discard", instruction_next, NOP_INSTR);
        adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("sameclk_target_pc", pc_next, 32'h200);
        adv();

        // Back-to-back redirects in S_REQ: the last target wins.
        do_reset();
        cyc(1'b0, 1'b1, 32'h300); adv();
        cyc(1'b0, 1'b1, 32'h404); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("b2b_req", {31'b0, imem_req}, 32'h1);
        chk("b2b_addr", imem_addr, 32'h404);
        adv();

        // PC wrap on the second instance.
        do_reset();
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_first_addr", imem_addr2, PC2);
        chk("wrap_first_req", {31'b0, imem_req2}, 32'h1);
        adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_pc_next", pc_next2, PC2);
        chk("wrap_pc_plus_four", pc_plus_four_next2, 32'h0);
        chk("wrap_next_addr", imem_addr2, 32'h0);
        chk("wrap_fetch_busy", {31'b0, fetch_busy2}, 32'h0);
        adv();

        // Asynchronous reset while a request is outstanding.
        do_reset();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        lat = 3;
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0); adv();
        cyc(1'b0, 1'b0, 32'h0);
        chk("midwait_pc_before", pc_next, 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("midwait_rst_req", {31'b0, imem_req}, 32'h0);
        chk("midwait_rst_pc", pc_next, 32'h0);
        chk("midwait_rst_instr", instruction_next, NOP_INSTR);
        chk("midwait_rst_busy", {31'b0, fetch_busy}, 32'h1);
        do_reset();
        cyc(1'b0, 1'b0, 32'h0);
        chk("midwait_fresh_req", {31'b0, imem_req}, 32'h1);
        chk("midwait_fresh_addr", imem_addr, 32'h0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined RV32I core, directly upstream of the IF/ID pipeline register.
- Owns the program counter.
- Issues requests to the L1 instruction cache over a req/ready + rvalid handshake.
- Buffers one returned instruction with its PC.
- Presents instruction_next / pc_next / pc_plus_four_next to IF/ID.
- Handles branch redirects, including discarding in-flight stale responses.

Parameters:
n, 32, data/address width
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
L1_busy  in  1  global stall (already includes fetch_busy); IF/ID captures when low
redirect_valid  in  1  branch taken / redirect request from execute
redirect_pc  in  n  redirect target; bits [1:0] ignored
imem_req  out  1  fetch request to L1 I-cache
imem_addr  out  n  fetch address, bits [1:0] always 00
imem_ready  in  1  I-cache accepts request this cycle
imem_rvalid  in  1  response data valid (one response per accepted request, in order, latency >= 1 cycle)
imem_rdata  in  n  returned instruction word
instruction_next  out  n  buffered instruction, or NOP 32'h00000013 when buffer empty
pc_next  out  n  PC of buffered instruction
pc_plus_four_next  out  n  pc_next + 4, modulo 2^n
fetch_busy  out  1  high when buffer empty; ORed into L1_busy at system level

Behaviour:
- Reset (async):
  - pc = RESET_PC; state = S_REQ; buf_valid = 0.
  - buf_instr = NOP; buf_pc = RESET_PC.
  - Outputs: imem_req = 0 during reset, instruction_next = NOP, pc_next = RESET_PC, fetch_busy = 1.
- consume = buf_valid & ~L1_busy. In a consume cycle the buffer is taken by IF/ID at the same clock edge.
- FSM states S_REQ, S_WAIT, S_DRAIN:
  - S_REQ: imem_req = (~buf_valid | consume) & ~redirect_valid; imem_addr = pc. If imem_req & imem_ready -> S_WAIT.
  - S_WAIT: imem_req = 0. On imem_rvalid: buf_instr = imem_rdata, buf_pc = pc, buf_valid = 1, pc = pc + 4, then -> S_REQ.
  - S_DRAIN: imem_req = 0. On imem_rvalid: data discarded, -> S_REQ.
- Buffer: consume without a same-cycle fill clears buf_valid. A fill and a consume in the same cycle is legal; buf_valid stays 1 with the new data. A fill never occurs while buf_valid & ~consume, which the S_REQ request gating guarantees.
- Redirect (redirect_valid = 1), highest priority. Regardless of L1_busy:
  - pc = {redirect_pc[n-1:2], 2'b00}; buf_valid = 0.
  - Next state:
    - S_REQ with no request accepted -> S_REQ. A request is never issued in the redirect cycle.
    - S_WAIT with imem_rvalid the same cycle -> response discarded, -> S_REQ.
    - S_WAIT without imem_rvalid -> S_DRAIN.
    - S_DRAIN -> S_DRAIN, or -> S_REQ if imem_rvalid the same cycle. The target pc is updated either way.
  - Back-to-back redirects: the last one wins.
- Latency: first request in the first cycle after reset deasserts. With 1-cycle I-cache latency, sustained throughput is one instruction per 2 cycles. Pipelining beyond one outstanding request is out of scope; at most one request is ever outstanding.
- Arithmetic: pc + 4 and buf_pc + 4 wrap modulo 2^n. 32'hFFFFFFFC + 4 = 0.
- Reset mid-transaction: state and buffer return to reset values immediately. A late imem_rvalid for the pre-reset request is the cache's responsibility (the cache is reset by the same signal).
- Assertions:
  - imem_rvalid only in S_WAIT or S_DRAIN.
  - imem_addr[1:0] == 0.
  - Never a fill while buf_valid & ~consume.

Decomposition:
- Shared package core_pkg: NOP_INSTR = 32'h00000013 (also used by instr_reg) and fetch_state_t enum {S_REQ, S_WAIT, S_DRAIN}.
- Single module, no sub-module. The one-entry buffer is too small to justify one.

Test Plan:
1. Reset, then reset deasserts with RESET_PC = 0, imem_ready = 1, 1-cycle rvalid returning 32'h00500093 -> first imem_req with imem_addr = 0; instruction_next = 32'h00500093, pc_next = 0, pc_plus_four_next = 4; next request at address 4.
2. L1_busy held high for 5 cycles with buffer full -> imem_req = 0 throughout; outputs stable. L1_busy low -> consumed; request to the next PC issued the same cycle.
3. Redirect to 32'h00000100 while in S_WAIT, response arriving 2 cycles later -> S_DRAIN; stale data never appears on instruction_next (stays NOP); next imem_addr = 32'h00000100.
4. Redirect to 32'h00000203 in the same cycle as imem_rvalid -> data discarded; next imem_addr = 32'h00000200; no S_DRAIN visit.
5. RESET_PC = 32'hFFFFFFFC sequential fetch -> pc_plus_four_next = 0; next imem_addr = 0.
6. Reset asserted mid-S_WAIT -> outputs return to NOP / RESET_PC asynchronously; fetch_busy = 1; fresh request after release.
